mode_timer: RTL and testbench
=============================

# mode_timer

Parametrised per-mode countdown timer for the lock controller. It watches the system state, loads a per-mode timeout in whole seconds on every state entry, and counts it down from a prescaled 1 s tick. It restarts the count on user activity and emits a one-cycle `finished` pulse to the system logic on expiry, or when `ok` is pressed in unlocked mode. It also exposes the remaining seconds for the display.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: clock cycles per second. The prescaler counts 0..CLK_HZ-1.
- `EDIT_TIMEOUT_S`, 10: editing-mode timeout in seconds. 0 disables the timeout.
- `UNLOCK_TIMEOUT_S`, 20: unlocked-mode timeout in seconds. 0 disables the timeout.
- `ALARM_TIMEOUT_S`, 0: alarming-mode timeout in seconds. 0 disables it, so the alarm holds until the state changes.
- `SEC_W`, 8: width of the seconds counter. Elaboration fails if any timeout is ≥ 2^SEC_W.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `state` in 2: system state. 00 waiting, 01 editing, 10 unlocked, 11 alarming.
- `ok` in 1: confirm button. A level input, synchronised and debounced upstream.
- `activity` in 1: one-cycle pulse on any switch, load or admin-button event.
- `finished` out 1: one-cycle pulse that requests a return to waiting.
- `sec_left` out SEC_W: remaining seconds of the active timeout. 0 when idle, disabled or expired.
- `tick_1s` out 1: one-cycle pulse every CLK_HZ cycles while a countdown is running.

## Operation
Reset:
- Applied on any edge with `rst`=1.
- Clears the prescaler, sets `sec_left`=0, `finished`=0 and `tick_1s`=0.
- Clears the ok-history bit, clears the expired flag and sets `state_q`=00.

State entry:
- On an edge where `state` ≠ `state_q`, `state_q` takes the new `state`.
- The prescaler clears.
- `sec_left` loads that state's timeout; waiting always loads 0.
- The expired flag clears.

Countdown:
- Runs when `sec_left` > 0, the expired flag is clear and no state-entry event occurs.
- The prescaler increments each cycle. At CLK_HZ-1 it wraps to 0, `tick_1s` pulses and `sec_left` decrements.

Expiry:
- On the tick where `sec_left` goes 1→0, `finished` pulses and the expired flag sets.
- After that the counter holds at 0 with no further pulses until the next state entry.

Activity:
- In editing or unlocked with the timeout not disabled, an `activity` pulse reloads `sec_left` to the mode's timeout and clears the prescaler.
- This applies even after expiry; the reload clears the expired flag.
- In waiting and alarming, activity is ignored.

Ok:
- In unlocked, a rising edge of `ok` (current `ok`=1 with the ok-history bit 0) pulses `finished`.
- It also sets `sec_left`=0 and the expired flag.
- `ok` in other states is ignored.

Waiting, and any state whose timeout is disabled: `sec_left`=0, the prescaler is held at 0, `tick_1s`=0 and `finished` never pulses.

## Timing
- All outputs are registered.
- `finished` is high for exactly the one cycle after the edge that detected expiry or the ok edge.
- Latency from a state change on `state` to the load of `sec_left`: one edge.
- First tick after entry: exactly CLK_HZ cycles after the load edge.
- A full timeout of T s expires T·CLK_HZ cycles after the load edge.

Priority at a single edge, highest first:
- `rst`.
- State entry. A pending expiry or ok in the same cycle is discarded; no pulse.
- Activity reload. Beats a same-cycle expiry; no pulse.
- Ok edge.
- Tick or expiry.

Other boundary cases:
- Ok and expiry in the same cycle produce a single one-cycle pulse.
- `rst` mid-count aborts the countdown with no pulse.
- If `state` is unchanged on the edge after reset and is non-waiting, that edge counts as an entry and loads that state's timeout.

## Structure
- Shared package `lock_pkg` holds:
  - the state encodings `ST_WAITING`, `ST_EDITING`, `ST_UNLOCKED` and `ST_ALARMING`;
  - the default timeout constants, so the system logic and display decoder use the same values.
- One sub-module, `tick_gen`:
  - parameter CLK_HZ; inputs `clk`, `rst`, `clear` and `enable`;
  - output `tick`, a one-cycle pulse;
  - counter width is $clog2(CLK_HZ).
- The top holds the state register, ok-history register, seconds counter, expired flag and pulse logic.

## Test plan
The bench runs with CLK_HZ=4, EDIT_TIMEOUT_S=3, UNLOCK_TIMEOUT_S=5 and ALARM_TIMEOUT_S=0.
- **Editing expiry:** reset, then `state`=01 → `sec_left`=3 on the next edge, then 2/1/0 at cycles +4/+8/+12. `finished` pulses once at +12 and stays 0 for the next 20 cycles.
- **Activity reload:** in editing, `activity` pulse at cycle 10 → `sec_left`=3, prescaler restarted, expiry at cycle 22 instead of 12.
- **Ok edge in unlocked:** `state`=10, `ok` held high from cycle 6 to 30 → a single `finished` pulse at cycle 7, `sec_left`=0, no pulse at cycle 20.
- **Collisions:** `activity` on the expiry cycle in editing → no pulse, `sec_left`=3. Ok edge on the expiry cycle in unlocked → exactly one pulse.
- **State entry pre-empts:** switch to 01 on the cycle unlocked would expire → no pulse, `sec_left`=3.
- **Disabled mode and reset:** alarming for 100 cycles → `sec_left`=0 and no ticks. `rst` mid-count in editing → all outputs 0, no pulse.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the lock controller: system state encodings and default per-mode timeouts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lock_pkg;

  // System state encodings, shared with the system logic and the display decoder.
  typedef enum logic [1:0] {
    ST_WAITING   = 2'b00,
    ST_EDITING   = 2'b01,
    ST_UNLOCKED  = 2'b10,
    ST_ALARMING  = 2'b11
  } state_e;

  // Default timeouts in whole seconds; 0 disables the timeout for that mode.
  localparam int DEF_CLK_HZ           = 50_000_000;
  localparam int DEF_EDIT_TIMEOUT_S   = 10;
  localparam int DEF_UNLOCK_TIMEOUT_S = 20;
  localparam int DEF_ALARM_TIMEOUT_S  = 0;
  localparam int DEF_SEC_W            = 8;

endpackage

// File: rtl/tick_gen.sv
// Prescaler that strobes once every CLK_HZ enabled cycles.
// Latency: tick is combinational on the last prescaler count; the count wraps on that same edge.
// Backpressure: none; a low enable or a clear parks the counter at 0.
// Ports: clk/rst (sync, active-high), clear (restart count), enable (count), tick (one-cycle strobe).
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = enable && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      // Parking at 0 keeps the first tick after any (re)start a full period away.
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mode_timer.sv
// Per-mode countdown timer: loads a timeout on state entry, counts whole seconds down, pulses finished on expiry or ok.
// Latency: all outputs registered; sec_left loads one edge after a state change, first tick CLK_HZ cycles later.
// Backpressure: none; activity reloads the count, a state change aborts it.
// Ports: clk, rst (sync, active-high), state[1:0], ok (level), activity (pulse);
//        finished (pulse), sec_left[SEC_W-1:0], tick_1s (pulse).
module mode_timer
  import lock_pkg::*;
#(
  parameter int CLK_HZ           = DEF_CLK_HZ,
  parameter int EDIT_TIMEOUT_S   = DEF_EDIT_TIMEOUT_S,
  parameter int UNLOCK_TIMEOUT_S = DEF_UNLOCK_TIMEOUT_S,
  parameter int ALARM_TIMEOUT_S  = DEF_ALARM_TIMEOUT_S,
  parameter int SEC_W            = DEF_SEC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       state,
  input  logic             ok,
  input  logic             activity,
  output logic             finished,
  output logic [SEC_W-1:0] sec_left,
  output logic             tick_1s
);

  generate
    if (EDIT_TIMEOUT_S >= (1 << SEC_W) || UNLOCK_TIMEOUT_S >= (1 << SEC_W) ||
        ALARM_TIMEOUT_S >= (1 << SEC_W)) begin : g_bad_timeout
      $error("mode_timer: a timeout does not fit in SEC_W bits");
    end
  endgenerate

  function automatic logic [SEC_W-1:0] timeout_of(input state_e s);
    case (s)
      ST_EDITING:  timeout_of = SEC_W'(EDIT_TIMEOUT_S);
      ST_UNLOCKED: timeout_of = SEC_W'(UNLOCK_TIMEOUT_S);
      ST_ALARMING: timeout_of = SEC_W'(ALARM_TIMEOUT_S);
      default:     timeout_of = '0;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic             ok_q, ok_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             expired_q, expired_d;
  logic             fin_q, fin_d;
  logic             tick_q, tick_d;

  logic [SEC_W-1:0] cur_to;
  logic             entry, reload, ok_edge, run, wrap;

  assign cur_to  = timeout_of(state_q);
  assign entry   = (state != state_q);
  // Activity only matters in the user-facing modes that actually time out.
  assign reload  = activity && (cur_to != '0) &&
                   ((state_q == ST_EDITING) || (state_q == ST_UNLOCKED));
  // Gated on a live timeout so a disabled or already finished mode never pulses twice.
  assign ok_edge = ok && !ok_q && (state_q == ST_UNLOCKED) && (cur_to != '0) && !expired_q;
  assign run     = (sec_q != '0) && !expired_q && !entry;

  tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (entry || reload),
    .enable(run),
    .tick  (wrap)
  );

  always_comb begin
    state_d   = state_q;
    ok_d      = ok;
    sec_d     = sec_q;
    expired_d = expired_q;
    fin_d     = 1'b0;
    tick_d    = 1'b0;
    if (entry) begin
      // Entry discards any expiry or ok edge landing on the same cycle.
      state_d   = state_e'(state);
      sec_d     = timeout_of(state_e'(state));
      expired_d = 1'b0;
    end else if (reload) begin
      sec_d     = cur_to;
      expired_d = 1'b0;
    end else if (ok_edge) begin
      // Covers a coincident expiry too: one pulse either way.
      fin_d     = 1'b1;
      sec_d     = '0;
      expired_d = 1'b1;
    end else if (wrap) begin
      tick_d = 1'b1;
      sec_d  = sec_q - SEC_W'(1);
      if (sec_q == SEC_W'(1)) begin
        fin_d     = 1'b1;
        expired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_WAITING;
      ok_q      <= 1'b0;
      sec_q     <= '0;
      expired_q <= 1'b0;
      fin_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ok_q      <= ok_d;
      sec_q     <= sec_d;
      expired_q <= expired_d;
      fin_q     <= fin_d;
      tick_q    <= tick_d;
    end
  end

  assign finished = fin_q;
  assign sec_left = sec_q;
  assign tick_1s  = tick_q;

endmodule

// File: tb/tb_mode_timer.sv
// Directed bench for mode_timer with CLK_HZ=4, edit=3 s, unlock=5 s, alarm disabled.
// Latency: inputs change 1 time unit after a rising edge; outputs are checked there too.
// Backpressure: n/a.
module tb_mode_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state = 2'b00;
  logic       ok = 1'b0;
  logic       activity = 1'b0;
  logic       finished;
  logic [7:0] sec_left;
  logic       tick_1s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mode_timer #(
    .CLK_HZ          (4),
    .EDIT_TIMEOUT_S  (3),
    .UNLOCK_TIMEOUT_S(5),
    .ALARM_TIMEOUT_S (0),
    .SEC_W           (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .state   (state),
    .ok      (ok),
    .activity(activity),
    .finished(finished),
    .sec_left(sec_left),
    .tick_1s (tick_1s)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles, counting finished pulses, ticks and cycles with a non-zero sec_left.
  task automatic run(input int n, output int fins, output int ticks, output int nz);
    fins = 0; ticks = 0; nz = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (finished) fins++;
      if (tick_1s) ticks++;
      if (sec_left != 0) nz++;
    end
  endtask

  // Enter a state from waiting; returns positioned at cycle 0 (the load edge).
  task automatic enter(input logic [1:0] s);
    state = 2'b00;
    step();
    state = s;
    step();
  endtask

  int f, t, z;

  initial begin
    // Reset state
    step(); step();
    chk("rst_sec", sec_left, 0);
    chk("rst_fin", finished, 0);
    chk("rst_tick", tick_1s, 0);

    // Editing expiry
    rst = 1'b0;
    state = 2'b01;
    step();
    chk("ed_load", sec_left, 3);
    run(3, f, t, z);
    chk("ed_c3_sec", sec_left, 3);
    chk("ed_c3_ticks", t, 0);
    step();
    chk("ed_c4_sec", sec_left, 2);
    chk("ed_c4_tick", tick_1s, 1);
    run(4, f, t, z);
    chk("ed_c8_sec", sec_left, 1);
    run(3, f, t, z);
    chk("ed_pre_fin", f, 0);
    step();
    chk("ed_c12_sec", sec_left, 0);
    chk("ed_c12_fin", finished, 1);
    run(20, f, t, z);
    chk("ed_post_fins", f, 0);
    chk("ed_post_ticks", t, 0);

    // Activity reload at cycle 10
    enter(2'b01);
    run(9, f, t, z);
    activity = 1'b1;
    step();
    activity = 1'b0;
    chk("act_c10_sec", sec_left, 3);
    run(11, f, t, z);
    chk("act_no_early_fin", f, 0);
    chk("act_c21_sec", sec_left, 1);
    step();
    chk("act_c22_fin", finished, 1);
    chk("act_c22_sec", sec_left, 0);

    // Ok edge in unlocked: ok high from cycle 6 to 30
    enter(2'b10);
    chk("ul_load", sec_left, 5);
    run(6, f, t, z);
    ok = 1'b1;
    step();
    chk("ok_c7_fin", finished, 1);
    chk("ok_c7_sec", sec_left, 0);
    run(23, f, t, z);
    chk("ok_held_fins", f, 0);
    chk("ok_held_ticks", t, 0);
    ok = 1'b0;

    // Activity on the editing expiry cycle
    enter(2'b01);
    run(11, f, t, z);
    activity = 1'b1;
    step();
    activity = 1'b0;
    chk("col_act_fin", finished, 0);
    chk("col_act_sec", sec_left, 3);

    // Ok edge on the unlocked expiry cycle
    enter(2'b10);
    run(19, f, t, z);
    chk("col_ok_pre_sec", sec_left, 1);
    ok = 1'b1;
    step();
    chk("col_ok_fin", finished, 1);
    chk("col_ok_sec", sec_left, 0);
    run(10, f, t, z);
    chk("col_ok_single", f, 0);
    ok = 1'b0;

    // State entry on the unlocked expiry cycle
    enter(2'b10);
    run(19, f, t, z);
    state = 2'b01;
    step();
    chk("pre_fin", finished, 0);
    chk("pre_sec", sec_left, 3);

    // Disabled alarming mode
    state = 2'b11;
    run(100, f, t, z);
    chk("alm_fins", f, 0);
    chk("alm_ticks", t, 0);
    chk("alm_nz", z, 0);

    // Reset mid-count in editing
    state = 2'b01;
    run(6, f, t, z);
    chk("mid_sec", sec_left, 2);
    rst = 1'b1;
    step();
    chk("mid_rst_sec", sec_left, 0);
    chk("mid_rst_fin", finished, 0);
    chk("mid_rst_tick", tick_1s, 0);
    run(13, f, t, z);
    chk("mid_rst_fins", f, 0);
    chk("mid_rst_nz", z, 0);
    rst = 1'b0;
    step();
    chk("post_rst_load", sec_left, 3);
    run(11, f, t, z);
    chk("post_rst_prefin", f, 0);
    step();
    chk("post_rst_fin", finished, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
